// File: rtl/load_resp_arbiter_pkg.sv
// Shared encodings and request record for the load response arbiter.
package load_resp_arbiter_pkg;

    // Access size field typ[1:0]
    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;
    localparam logic [1:0] MEM_SZ_D = 2'b11;

    // typ[TYP_UNSIGNED]=1 selects zero-extension
    localparam int TYP_UNSIGNED = 2;

    // Tag width carried by the request record; the arbiter's TAG_W must match it
    localparam int LR_TAG_W = 6;

    typedef struct packed {
        logic [LR_TAG_W-1:0] tag;
        logic [2:0]          typ;
        logic [2:0]          addr_lo;
        logic [63:0]         data;
        logic                zero;
    } load_req_t;

endpackage

// File: rtl/load_data_align.sv
// Combinational load extractor: lane select by byte offset, then sign/zero
// extension per access size. zero forces the full-width result only.
module load_data_align
    import load_resp_arbiter_pkg::*;
(
    input  logic [2:0]  typ_i,
    input  logic [2:0]  addr_lo_i,
    input  logic [63:0] raw_i,
    input  logic        zero_i,
    output logic [63:0] data_o,
    output logic [63:0] data_word_o
);

    logic [31:0] w32;
    logic [15:0] h16;
    logic [7:0]  b8;
    logic [63:0] ext;
    logic        uns;

    // Narrow the doubleword down to the addressed word, half and byte, then extend
    always_comb begin
        w32 = addr_lo_i[2] ? raw_i[63:32] : raw_i[31:0];
        h16 = addr_lo_i[1] ? w32[31:16]   : w32[15:0];
        b8  = addr_lo_i[0] ? h16[15:8]    : h16[7:0];
        uns = typ_i[TYP_UNSIGNED];
        ext = raw_i;
        case (typ_i[1:0])
            MEM_SZ_B: ext = uns ? {56'd0, b8}  : {{56{b8[7]}}, b8};
            MEM_SZ_H: ext = uns ? {48'd0, h16} : {{48{h16[15]}}, h16};
            MEM_SZ_W: ext = uns ? {32'd0, w32} : {{32{w32[31]}}, w32};
            default:  ext = raw_i;
        endcase
        data_o      = zero_i ? 64'd0 : ext;
        data_word_o = (typ_i[1:0] == MEM_SZ_W) ? ext : {raw_i[63:32], w32};
    end

endmodule

// File: rtl/load_resp_arbiter.sv
// Load response arbiter: hits always own the shared extractor; MSHR replays
// wait in a circular queue and drain on hit-free cycles. Output is registered.
// Optional feature: define LOAD_RESP_RP_BYPASS_EN to let a replay arriving on
// an idle cycle with an empty queue go straight to the extractor.
module load_resp_arbiter
    import load_resp_arbiter_pkg::*;
#(
    parameter int TAG_W    = LR_TAG_W,
    parameter int RQ_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hit_valid,
    input  logic                      hit_kill,
    input  logic [TAG_W-1:0]          hit_tag,
    input  logic [2:0]                hit_typ,
    input  logic [2:0]                hit_addr_lo,
    input  logic [63:0]               hit_data,
    input  logic                      hit_zero,
    output logic                      hit_block,
    input  logic                      rp_valid,
    output logic                      rp_ready,
    input  logic [TAG_W-1:0]          rp_tag,
    input  logic [2:0]                rp_typ,
    input  logic [2:0]                rp_addr_lo,
    input  logic [63:0]               rp_data,
    output logic                      resp_valid,
    output logic                      resp_src,
    output logic [TAG_W-1:0]          resp_tag,
    output logic [63:0]               resp_data,
    output logic [63:0]               resp_data_word,
    output logic [$clog2(RQ_DEPTH):0] rq_count
);

    localparam int PTR_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(RQ_DEPTH) + 1;

    load_req_t          rq_mem_q [RQ_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    load_req_t          hit_req, rp_req, sel_req;
    logic               sel_vld, sel_src;
    logic               rp_fire, deq, byp, wr;
    logic [63:0]        ext_data, ext_word;

    logic               resp_valid_q;
    logic               resp_src_q;
    logic [TAG_W-1:0]   resp_tag_q;
    logic [63:0]        resp_data_q;
    logic [63:0]        resp_word_q;

    // Ready is a function of the registered count only, never of a same-cycle dequeue
    assign rp_ready  = !reset && (count_q < CNT_W'(RQ_DEPTH));
    assign hit_block = (count_q == CNT_W'(RQ_DEPTH));
    assign rp_fire   = rp_valid && rp_ready;
    assign rq_count  = count_q;

    // Package the two request sources into the common record
    always_comb begin
        hit_req         = '0;
        hit_req.tag     = LR_TAG_W'(hit_tag);
        hit_req.typ     = hit_typ;
        hit_req.addr_lo = hit_addr_lo;
        hit_req.data    = hit_data;
        hit_req.zero    = hit_zero;
        rp_req          = '0;
        rp_req.tag      = LR_TAG_W'(rp_tag);
        rp_req.typ      = rp_typ;
        rp_req.addr_lo  = rp_addr_lo;
        rp_req.data     = rp_data;
        rp_req.zero     = 1'b0;
    end

    // Extractor select: a presented hit (even a killed one) blocks the queue
    always_comb begin
        sel_req = hit_req;
        sel_vld = 1'b0;
        sel_src = 1'b0;
        deq     = 1'b0;
        byp     = 1'b0;
        if (hit_valid) begin
            sel_vld = !hit_kill;
        end else if (count_q != '0) begin
            sel_req = rq_mem_q[head_q];
            sel_vld = 1'b1;
            sel_src = 1'b1;
            deq     = 1'b1;
        end
`ifdef LOAD_RESP_RP_BYPASS_EN
        else if (rp_fire) begin
            sel_req = rp_req;
            sel_vld = 1'b1;
            sel_src = 1'b1;
            byp     = 1'b1;
        end
`endif
    end

    assign wr = rp_fire && !byp;

    // Queue pointer and occupancy next-state; both pointers wrap naturally
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) head_d = head_q + PTR_W'(1);
        if (wr)  tail_d = tail_q + PTR_W'(1);
        case ({wr, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue control state; reset empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (wr) rq_mem_q[tail_q] <= rp_req;
    end

    load_data_align u_align (
        .typ_i       (sel_req.typ),
        .addr_lo_i   (sel_req.addr_lo),
        .raw_i       (sel_req.data),
        .zero_i      (sel_req.zero),
        .data_o      (ext_data),
        .data_word_o (ext_word)
    );

    // Registered response stage; payload holds when no response is produced
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_src_q   <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_word_q  <= '0;
        end else begin
            resp_valid_q <= sel_vld;
            if (sel_vld) begin
                resp_src_q  <= sel_src;
                resp_tag_q  <= TAG_W'(sel_req.tag);
                resp_data_q <= ext_data;
                resp_word_q <= ext_word;
            end
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_src       = resp_src_q;
    assign resp_tag       = resp_tag_q;
    assign resp_data      = resp_data_q;
    assign resp_data_word = resp_word_q;

endmodule

// File: tb/tb_load_resp_arbiter.sv
// Directed bench for load_resp_arbiter: a table of hit extraction vectors
// followed by hand-written replay, backpressure, kill and reset sequences.
module tb_load_resp_arbiter;

    localparam int TAG_W    = 6;
    localparam int RQ_DEPTH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              hit_valid, hit_kill, hit_zero;
    logic [TAG_W-1:0]  hit_tag;
    logic [2:0]        hit_typ, hit_addr_lo;
    logic [63:0]       hit_data;
    logic              hit_block;
    logic              rp_valid, rp_ready;
    logic [TAG_W-1:0]  rp_tag;
    logic [2:0]        rp_typ, rp_addr_lo;
    logic [63:0]       rp_data;
    logic              resp_valid, resp_src;
    logic [TAG_W-1:0]  resp_tag;
    logic [63:0]       resp_data, resp_data_word;
    logic [$clog2(RQ_DEPTH):0] rq_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_resp_arbiter #(.TAG_W(TAG_W), .RQ_DEPTH(RQ_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .hit_valid(hit_valid), .hit_kill(hit_kill), .hit_tag(hit_tag),
        .hit_typ(hit_typ), .hit_addr_lo(hit_addr_lo), .hit_data(hit_data),
        .hit_zero(hit_zero), .hit_block(hit_block),
        .rp_valid(rp_valid), .rp_ready(rp_ready), .rp_tag(rp_tag),
        .rp_typ(rp_typ), .rp_addr_lo(rp_addr_lo), .rp_data(rp_data),
        .resp_valid(resp_valid), .resp_src(resp_src), .resp_tag(resp_tag),
        .resp_data(resp_data), .resp_data_word(resp_data_word),
        .rq_count(rq_count)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [2:0]  addr;
        logic [63:0] data;
        logic        zero;
        logic        kill;
        logic        exp_vld;
        logic [63:0] exp_data;
        logic [63:0] exp_word;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{3'b000, 3'd3, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_8000_0000};
        vecs[1] = '{3'b110, 3'd4, 64'h8765_4321_DEAD_BEEF, 1'b0, 1'b0, 1'b1, 64'h0000_0000_8765_4321, 64'h0000_0000_8765_4321};
        vecs[2] = '{3'b110, 3'd4, 64'h8765_4321_DEAD_BEEF, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_8765_4321};
        vecs[3] = '{3'b100, 3'd3, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0080, 64'h0000_0000_8000_0000};
        vecs[4] = '{3'b001, 3'd6, 64'h8001_0000_0000_0000, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 64'h8001_0000_8001_0000};
        vecs[5] = '{3'b101, 3'd6, 64'h8001_0000_0000_0000, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_8001, 64'h8001_0000_8001_0000};
        vecs[6] = '{3'b010, 3'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0, 64'hFFFF_FFFF_9ABC_DEF0};
        vecs[7] = '{3'b011, 3'd5, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_0123_4567};
        vecs[8] = '{3'b000, 3'd1, 64'h0000_0000_0000_7F00, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_7F00};
        vecs[9] = '{3'b011, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};

        reset = 1'b1;
        hit_valid = 1'b0; hit_kill = 1'b0; hit_zero = 1'b0; hit_tag = '0;
        hit_typ = '0; hit_addr_lo = '0; hit_data = '0;
        rp_valid = 1'b0; rp_tag = '0; rp_typ = 3'b011; rp_addr_lo = '0; rp_data = '0;

        // Reset state
        step();
        step();
        chk("rp_ready_in_reset", 64'(rp_ready), 64'd0);
        reset = 1'b0;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_src", 64'(resp_src), 64'd0);
        chk("rst_resp_tag", 64'(resp_tag), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_word", resp_data_word, 64'd0);
        chk("rst_rq_count", 64'(rq_count), 64'd0);
        chk("rst_hit_block", 64'(hit_block), 64'd0);
        step();
        chk("rp_ready_after_reset", 64'(rp_ready), 64'd1);

        // Hit extraction table, one-cycle latency
        for (int i = 0; i < 10; i++) begin
            hit_valid   = 1'b1;
            hit_tag     = TAG_W'(i + 20);
            hit_typ     = vecs[i].typ;
            hit_addr_lo = vecs[i].addr;
            hit_data    = vecs[i].data;
            hit_zero    = vecs[i].zero;
            hit_kill    = vecs[i].kill;
            step();
            hit_valid = 1'b0; hit_kill = 1'b0; hit_zero = 1'b0;
            chk($sformatf("v%0d_valid", i), 64'(resp_valid), 64'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
                chk($sformatf("v%0d_word", i), resp_data_word, vecs[i].exp_word);
                chk($sformatf("v%0d_src", i), 64'(resp_src), 64'd0);
                chk($sformatf("v%0d_tag", i), 64'(resp_tag), 64'(i + 20));
            end
        end
        step();
        chk("idle_no_resp", 64'(resp_valid), 64'd0);

        // Single replay on an idle cycle
        rp_valid = 1'b1; rp_tag = 6'd5; rp_typ = 3'b010; rp_addr_lo = 3'd4;
        rp_data = 64'hC000_0001_0000_0000;
        step();
        rp_valid = 1'b0;
`ifdef LOAD_RESP_RP_BYPASS_EN
        chk("rp1_valid_t1", 64'(resp_valid), 64'd1);
        chk("rp1_count_t1", 64'(rq_count), 64'd0);
`else
        chk("rp1_valid_t1", 64'(resp_valid), 64'd0);
        chk("rp1_count_t1", 64'(rq_count), 64'd1);
        step();
        chk("rp1_valid_t2", 64'(resp_valid), 64'd1);
`endif
        chk("rp1_src", 64'(resp_src), 64'd1);
        chk("rp1_tag", 64'(resp_tag), 64'd5);
        chk("rp1_data", resp_data, 64'hFFFF_FFFF_C000_0001);
        chk("rp1_count_end", 64'(rq_count), 64'd0);
        step();
        chk("rp1_done", 64'(resp_valid), 64'd0);

        // Three replays under continuous hits: queue fills and backpressures
        hit_valid = 1'b1; hit_tag = 6'd40; hit_typ = 3'b011; hit_data = 64'h55;
        rp_valid = 1'b1; rp_tag = 6'd1; rp_typ = 3'b011; rp_data = 64'h11;
        step();
        chk("fill_count1", 64'(rq_count), 64'd1);
        rp_tag = 6'd2; rp_data = 64'h22;
        step();
        chk("fill_count2", 64'(rq_count), 64'd2);
        chk("fill_hit_src", 64'(resp_src), 64'd0);
        chk("fill_hit_tag", 64'(resp_tag), 64'd40);
        rp_tag = 6'd3; rp_data = 64'h33;
        chk("full_rp_ready", 64'(rp_ready), 64'd0);
        chk("full_hit_block", 64'(hit_block), 64'd1);
        step();
        chk("full_count_hold", 64'(rq_count), 64'd2);
        chk("full_hit_still_wins", 64'(resp_src), 64'd0);
        hit_valid = 1'b0;
        step();
        chk("drain1_tag", 64'(resp_tag), 64'd1);
        chk("drain1_src", 64'(resp_src), 64'd1);
        chk("drain1_data", resp_data, 64'h11);
        chk("drain1_count", 64'(rq_count), 64'd1);
        step();
        rp_valid = 1'b0;
        chk("drain2_tag", 64'(resp_tag), 64'd2);
        chk("drain2_count_same", 64'(rq_count), 64'd1);
        step();
        chk("drain3_tag", 64'(resp_tag), 64'd3);
        chk("drain3_valid", 64'(resp_valid), 64'd1);
        chk("drain3_count", 64'(rq_count), 64'd0);
        step();
        chk("drain_done", 64'(resp_valid), 64'd0);

        // Killed hit still blocks the queued replay
        hit_valid = 1'b1; hit_kill = 1'b1;
        rp_valid = 1'b1; rp_tag = 6'd9; rp_data = 64'h99;
        step();
        rp_valid = 1'b0;
        chk("kill_enq_count", 64'(rq_count), 64'd1);
        chk("kill_no_resp1", 64'(resp_valid), 64'd0);
        step();
        hit_valid = 1'b0; hit_kill = 1'b0;
        chk("kill_no_resp2", 64'(resp_valid), 64'd0);
        chk("kill_count_held", 64'(rq_count), 64'd1);
        step();
        chk("kill_rp_valid", 64'(resp_valid), 64'd1);
        chk("kill_rp_tag", 64'(resp_tag), 64'd9);
        step();

        // Reset with two queued entries discards them
        hit_valid = 1'b1; hit_kill = 1'b0;
        rp_valid = 1'b1; rp_tag = 6'd10;
        step();
        rp_tag = 6'd11;
        step();
        rp_valid = 1'b0;
        chk("pre_rst_count", 64'(rq_count), 64'd2);
        reset = 1'b1;
        hit_valid = 1'b0;
        step();
        chk("mid_rst_rp_ready", 64'(rp_ready), 64'd0);
        reset = 1'b0;
        chk("mid_rst_count", 64'(rq_count), 64'd0);
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst_idle%0d", k), 64'(resp_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
